// File: rtl/tdc_thermo_encoder_pipe.sv
// tdc_thermo_encoder_pipe
// Three-stage thermometer-to-binary encoder for the TDC delay-line readout.
//   S1 captures the raw code, S2 applies 3-tap majority bubble correction,
//   S3 priority-encodes the corrected code and registers the output flags.
//   A saturating counter tracks how many output samples needed correction.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   thermo_valid_i raw code valid this cycle
//   thermo_i       raw LSB-filled thermometer code
//   cnt_clear_i    synchronous clear of bubble_cnt_o (wins over increment)
//   bin_valid_o    bin_o/overflow_o/bubble_o valid this cycle
//   bin_o          encoded fine time (ones count, saturated)
//   overflow_o     ones count exceeded the bin_o range
//   bubble_o       correction changed at least one bit of this sample
//   bubble_cnt_o   saturating count of corrected samples
module tdc_thermo_encoder_pipe #(
    parameter int THERMO_WIDTH = 32,
    parameter int BIN_WIDTH    = 5,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    thermo_valid_i,
    input  logic [THERMO_WIDTH-1:0] thermo_i,
    input  logic                    cnt_clear_i,
    output logic                    bin_valid_o,
    output logic [BIN_WIDTH-1:0]    bin_o,
    output logic                    overflow_o,
    output logic                    bubble_o,
    output logic [CNT_WIDTH-1:0]    bubble_cnt_o
);

    localparam int BIN_MAX = 2**BIN_WIDTH - 1;

    // S1 registers
    logic                    valid_s1_q;
    logic [THERMO_WIDTH-1:0] thermo_s1_q;

    // S2 registers
    logic                    valid_s2_q;
    logic [THERMO_WIDTH-1:0] corr_s2_q;
    logic                    bubble_s2_q;

    // S3 registers
    logic                    valid_s3_q;
    logic [BIN_WIDTH-1:0]    bin_q;
    logic                    overflow_q;
    logic                    bubble_q;

    logic [CNT_WIDTH-1:0]    cnt_q;

    // S2 combinational: majority filter. The code is padded with a 1 below
    // the LSB and a 0 above the MSB so the end taps see a clean boundary.
    logic [THERMO_WIDTH+1:0] ext_s1;
    logic [THERMO_WIDTH-1:0] corr_d;
    logic                    bubble_s2_d;

    always_comb begin
        ext_s1 = {1'b0, thermo_s1_q, 1'b1};
        corr_d = '0;
        for (int i = 0; i < THERMO_WIDTH; i++) begin
            corr_d[i] = (ext_s1[i]   & ext_s1[i+1]) |
                        (ext_s1[i]   & ext_s1[i+2]) |
                        (ext_s1[i+1] & ext_s1[i+2]);
        end
        bubble_s2_d = (corr_d != thermo_s1_q);
    end

    // S3 combinational: highest set bit + 1, so residual multi-bit bubbles
    // are still encoded by their top edge.
    int                   ones_n;
    logic [BIN_WIDTH-1:0] bin_d;
    logic                 overflow_d;

    always_comb begin
        ones_n = 0;
        for (int i = 0; i < THERMO_WIDTH; i++) begin
            if (corr_s2_q[i]) begin
                ones_n = i + 1;
            end
        end
        overflow_d = (ones_n > BIN_MAX);
        bin_d      = overflow_d ? '1 : BIN_WIDTH'(ones_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_s1_q  <= 1'b0;
            thermo_s1_q <= '0;
            valid_s2_q  <= 1'b0;
            corr_s2_q   <= '0;
            bubble_s2_q <= 1'b0;
            valid_s3_q  <= 1'b0;
            bin_q       <= '0;
            overflow_q  <= 1'b0;
            bubble_q    <= 1'b0;
        end else begin
            valid_s1_q <= thermo_valid_i;
            if (thermo_valid_i) begin
                thermo_s1_q <= thermo_i;
            end

            valid_s2_q <= valid_s1_q;
            if (valid_s1_q) begin
                corr_s2_q   <= corr_d;
                bubble_s2_q <= bubble_s2_d;
            end

            // bin/overflow hold across idle cycles; bubble is only
            // meaningful alongside a valid output.
            valid_s3_q <= valid_s2_q;
            bubble_q   <= valid_s2_q & bubble_s2_q;
            if (valid_s2_q) begin
                bin_q      <= bin_d;
                overflow_q <= overflow_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_clear_i) begin
            cnt_q <= '0;
        end else if (valid_s3_q && bubble_q && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bin_valid_o  = valid_s3_q;
    assign bin_o        = bin_q;
    assign overflow_o   = overflow_q;
    assign bubble_o     = bubble_q;
    assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_tdc_thermo_encoder_pipe.sv
// Scoreboard bench for tdc_thermo_encoder_pipe. A second instance with a
// 4-bit counter shares the stimulus to exercise counter saturation.
module tb_tdc_thermo_encoder_pipe;

    localparam int TW     = 32;
    localparam int BW     = 5;
    localparam int CW     = 16;
    localparam int CW_SAT = 4;

    typedef struct {
        int bin;
        bit ovf;
        bit bub;
        int t_out;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          thermo_valid = 1'b0;
    logic [TW-1:0] thermo = '0;
    logic          cnt_clear = 1'b0;

    logic          bin_valid, overflow, bubble;
    logic [BW-1:0] bin;
    logic [CW-1:0] bubble_cnt;

    logic              s_bin_valid, s_overflow, s_bubble;
    logic [BW-1:0]     s_bin;
    logic [CW_SAT-1:0] s_bubble_cnt;

    tdc_thermo_encoder_pipe #(.THERMO_WIDTH(TW), .BIN_WIDTH(BW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .thermo_valid_i(thermo_valid), .thermo_i(thermo),
        .cnt_clear_i(cnt_clear), .bin_valid_o(bin_valid), .bin_o(bin),
        .overflow_o(overflow), .bubble_o(bubble), .bubble_cnt_o(bubble_cnt)
    );

    tdc_thermo_encoder_pipe #(.THERMO_WIDTH(TW), .BIN_WIDTH(BW), .CNT_WIDTH(CW_SAT)) dut_sat (
        .clk(clk), .rst_n(rst_n), .thermo_valid_i(thermo_valid), .thermo_i(thermo),
        .cnt_clear_i(cnt_clear), .bin_valid_o(s_bin_valid), .bin_o(s_bin),
        .overflow_o(s_overflow), .bubble_o(s_bubble), .bubble_cnt_o(s_bubble_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t sb[$];

    task automatic check(input string name, input longint act, input longint expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: correct each tap by a vote of itself and its neighbours,
    // then count up to the highest surviving one.
    function automatic exp_t ref_model(input logic [TW-1:0] t);
        exp_t e;
        int   ext[TW+2];
        int   c;
        int   n = 0;
        e.bub = 1'b0;
        ext[0] = 1;
        ext[TW+1] = 0;
        for (int i = 0; i < TW; i++) ext[i+1] = t[i] ? 1 : 0;
        for (int i = 0; i < TW; i++) begin
            c = (ext[i] + ext[i+1] + ext[i+2] >= 2) ? 1 : 0;
            if (c != ext[i+1]) e.bub = 1'b1;
            if (c == 1) n = i + 1;
        end
        if (n > 2**BW - 1) begin
            e.bin = 2**BW - 1;
            e.ovf = 1'b1;
        end else begin
            e.bin = n;
            e.ovf = 1'b0;
        end
        e.t_out = 0;
        return e;
    endfunction

    // Monitor: pops the scoreboard on every bin_valid and models bubble_cnt.
    int exp_cnt = 0;
    int exp_cnt_sat = 0;
    int last_bin = 0;
    bit last_ovf = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        bit   inc;
        inc = 1'b0;
        if (!rst_n) begin
            sb.delete();
            exp_cnt = 0;
            exp_cnt_sat = 0;
            last_bin = 0;
            last_ovf = 1'b0;
            check("rst_bin_valid", bin_valid, 0);
            check("rst_bin", bin, 0);
            check("rst_overflow", overflow, 0);
            check("rst_bubble", bubble, 0);
            check("rst_cnt", bubble_cnt, 0);
        end else begin
            check("bubble_cnt", bubble_cnt, exp_cnt);
            check("bubble_cnt_sat", s_bubble_cnt, exp_cnt_sat);
            if (bin_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", bin_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("latency_cycle", cyc, e.t_out);
                    check("bin", bin, e.bin);
                    check("overflow", overflow, e.ovf);
                    check("bubble", bubble, e.bub);
                    last_bin = e.bin;
                    last_ovf = e.ovf;
                    inc = e.bub;
                end
            end else begin
                check("hold_bin", bin, last_bin);
                check("hold_overflow", overflow, last_ovf);
                check("idle_bubble", bubble, 0);
            end
            if (cnt_clear) begin
                exp_cnt = 0;
                exp_cnt_sat = 0;
            end else if (inc) begin
                if (exp_cnt < 2**CW - 1) exp_cnt++;
                if (exp_cnt_sat < 2**CW_SAT - 1) exp_cnt_sat++;
            end
        end
    end

    // Drive one cycle, starting just after a rising edge.
    task automatic drive(input logic [TW-1:0] t, input bit v, input bit use_exp,
                         input int xbin, input bit xovf, input bit xbub);
        exp_t e;
        thermo_valid = v;
        thermo = t;
        if (v) begin
            if (use_exp) begin
                e.bin = xbin;
                e.ovf = xovf;
                e.bub = xbub;
            end else begin
                e = ref_model(t);
            end
            e.t_out = cyc + 3;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic drain;
        int k = 0;
        while (sb.size() != 0 && k < 20) begin
            idle(1);
            k++;
        end
        check("drain_empty", sb.size(), 0);
        idle(1);
    endtask

    function automatic logic [TW-1:0] clean_code(input int n);
        logic [63:0] tmp;
        tmp = (64'd1 << n) - 64'd1;
        return tmp[TW-1:0];
    endfunction

    initial begin
        logic [TW-1:0] t;
        int            n;
        int            j;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(5);
        check("idle_cnt", bubble_cnt, 0);

        // Directed codes with hand-derived expectations.
        drive(32'h0000_00FF, 1'b1, 1'b1, 8,  1'b0, 1'b0);
        drive(32'h0000_0000, 1'b1, 1'b1, 0,  1'b0, 1'b0);
        drive(32'h0000_00FB, 1'b1, 1'b1, 8,  1'b0, 1'b1);
        drive(32'h0000_0107, 1'b1, 1'b1, 3,  1'b0, 1'b1);
        drive(32'hFFFF_FFFF, 1'b1, 1'b1, 31, 1'b1, 1'b0);
        drive(32'h7FFF_FFFF, 1'b1, 1'b1, 31, 1'b0, 1'b0);
        drain();
        check("cnt_after_directed", bubble_cnt, 2);

        cnt_clear = 1'b1;
        idle(1);
        cnt_clear = 1'b0;

        // 20 back-to-back samples, every 4th with an interior hole.
        for (int i = 0; i < 20; i++) begin
            n = $urandom_range(3, 28);
            t = clean_code(n);
            if (i % 4 == 0) begin
                j = $urandom_range(1, n - 2);
                t[j] = 1'b0;
            end
            drive(t, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        end
        drain();
        check("stream_cnt", bubble_cnt, 5);

        // Clear coinciding with a bubble output: clear must win.
        drive(32'h0000_00FB, 1'b1, 1'b1, 8, 1'b0, 1'b1);
        idle(2);
        cnt_clear = 1'b1;
        idle(1);
        cnt_clear = 1'b0;
        idle(1);
        check("clear_vs_incr", bubble_cnt, 0);

        // Saturation of the narrow counter.
        for (int i = 0; i < 20; i++) drive(32'h0000_00FB, 1'b1, 1'b1, 8, 1'b0, 1'b1);
        drain();
        check("sat_cnt", s_bubble_cnt, 15);
        check("wide_cnt_20", bubble_cnt, 20);
        idle(3);
        check("sat_cnt_held", s_bubble_cnt, 15);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: t = clean_code($urandom_range(0, TW));
                1: begin
                    t = clean_code($urandom_range(0, TW));
                    t[$urandom_range(0, TW - 1)] ^= 1'b1;
                end
                2: t = $urandom;
                default: begin
                    t = clean_code($urandom_range(TW - 3, TW));
                    if ($urandom_range(0, 1) == 1) t[$urandom_range(0, TW - 1)] ^= 1'b1;
                end
            endcase
            drive(t, ($urandom_range(0, 9) < 7), 1'b0, 0, 1'b0, 1'b0);
            if ($urandom_range(0, 49) == 0) begin
                cnt_clear = 1'b1;
                idle(1);
                cnt_clear = 1'b0;
            end
        end
        drain();

        // Reset with two samples in flight: none may emerge afterwards.
        drive(32'h0000_00FB, 1'b1, 1'b1, 8, 1'b0, 1'b1);
        drive(32'h0000_FFFF, 1'b1, 1'b1, 16, 1'b0, 1'b0);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(6);
        check("post_reset_queue", sb.size(), 0);
        check("post_reset_cnt", bubble_cnt, 0);
        check("post_reset_bin", bin, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
